// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state type, datapath widths, the halt
// encoding and the jump target table (also emitted by the assembler).
package cpu_pkg;

  localparam int unsigned PC_W      = 10;
  localparam int unsigned INSTR_W   = 9;
  localparam int unsigned LUT_IDX_W = 4;
  localparam int unsigned LUT_DEPTH = 1 << LUT_IDX_W;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } fetch_state_t;

  // Jump targets, indexed by the decoder's 4-bit jump immediate.
  localparam logic [PC_W-1:0] JUMP_LUT [LUT_DEPTH] = '{
    10'd0,   10'd17,  10'd100, 10'd40,
    10'd64,  10'd200, 10'd333, 10'd512,
    10'd7,   10'd900, 10'd1000, 10'd1023,
    10'd256, 10'd128, 10'd3,   10'd777
  };

endpackage

// File: rtl/branch_lut.sv
// Jump target lookup: combinational map from jump-table index to PC target.
//   idx    in  LUT_IDX_W  table index (decoder imm[3:0])
//   target out PC_W       resolved jump target
module branch_lut
  import cpu_pkg::*;
(
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [PC_W-1:0]      target
);

  assign target = JUMP_LUT[idx];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC and instruction ROM, presents one registered
// instruction per cycle to the decoder, resolves taken jumps through the jump
// table and runs a start/done program handshake.
//   clk          in  1        clock
//   reset_n      in  1        asynchronous active-low reset
//   start        in  1        pulse: begin execution at PC 0 (IDLE/HALT only)
//   stall        in  1        downstream busy; freeze fetch state
//   branch_taken in  1        instruction now in instr is a taken jump
//   branch_idx   in  4        jump table index, valid with branch_taken
//   pc           out PC_W     current fetch address
//   instr        out INSTR_W  registered instruction
//   instr_valid  out 1        instr is real (0 = bubble)
//   done         out 1        high while halted
module instr_fetch
  import cpu_pkg::*;
#(
  parameter string PROG_FILE = "machine_code.txt"
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  output logic [PC_W-1:0]      pc,
  output logic [INSTR_W-1:0]   instr,
  output logic                 instr_valid,
  output logic                 done
);

  localparam int unsigned RomDepth = 1 << PC_W;

  fetch_state_t       state_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;
  logic               done_q;

  logic [INSTR_W-1:0] rom [RomDepth];
  logic [INSTR_W-1:0] rom_data;
  logic [PC_W-1:0]    jump_target;

  assign rom_data = rom[pc_q];

  branch_lut u_branch_lut (
    .idx    (branch_idx),
    .target (jump_target)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            pc_q    <= '0;
            valid_q <= 1'b0;
          end
        end
        FETCH: begin
          // Priority: stall > branch > halt > sequential fetch.
          if (stall) begin
            // hold everything; decode re-asserts branch_taken afterwards
          end else if (branch_taken && valid_q) begin
            // Bubble flushes the wrong-path fetch already in flight.
            pc_q    <= jump_target;
            instr_q <= '0;
            valid_q <= 1'b0;
          end else if (valid_q && (instr_q == HALT_INSTR)) begin
            state_q <= HALT;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            instr_q <= rom_data;
            valid_q <= 1'b1;
            pc_q    <= pc_q + PC_W'(1);
          end
        end
        HALT: begin
          if (start) begin
            state_q <= FETCH;
            pc_q    <= '0;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign done        = done_q;

endmodule
